// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requestor round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        return req_idx_t'((int'(idx) + 1) % N_REQ);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first valid requestor at or after ptr.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [3:0] in_valid,
    input  req_idx_t   ptr,
    output logic       any,
    output req_idx_t   g,
    output logic [3:0] grant
);

    req_idx_t idx;
    logic     found;

    always_comb begin
        found = 1'b0;
        g     = ptr;
        idx   = ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr + req_idx_t'(k);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        any   = found;
        grant = found ? (4'b0001 << g) : '0;
    end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Round-robin arbiter over four requestors feeding a one-entry registered output.
module rr_arb_mux_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    req_idx_t     out_sel_q, out_sel_d;
    req_idx_t     ptr_q, ptr_d;

    logic         any;
    req_idx_t     g;
    logic [3:0]   grant;
    logic         can_load;
    logic         load;
    logic [W-1:0] pick_data;

    rr_pick_4 u_pick (
        .in_valid (in_valid),
        .ptr      (ptr_q),
        .any      (any),
        .g        (g),
        .grant    (grant)
    );

    assign can_load = !out_valid_q || out_ready;
    // rst gate keeps requestors from seeing an accept while the registers are held in reset
    assign load     = can_load && any && !rst;
    assign in_ready = load ? grant : '0;

    always_comb begin
        case (g)
            2'd0:    pick_data = d0;
            2'd1:    pick_data = d1;
            2'd2:    pick_data = d2;
            default: pick_data = d3;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (can_load) begin
            if (any) begin
                out_valid_d = 1'b1;
                out_data_d  = pick_data;
                out_sel_d   = g;
                ptr_d       = next_idx(g);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Directed self-checking bench for rr_arb_mux_4 with hand-computed expectations.
module tb_rr_arb_mux_4;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int unsigned n_total;
    int unsigned n_bad;

    rr_arb_mux_4 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".sel"}, {30'd0, out_sel}, {30'd0, s});
        chk({tag, ".data"}, {28'd0, out_data}, {28'd0, d});
    endtask

    logic [3:0] sp_ready [8];
    logic [1:0] sp_sel   [8];
    logic       sp_ordy  [8];

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;

        #1;
        chk_out("reset", 1'b0, 2'd0, 4'h0);
        chk("reset.in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // round-robin order with full occupancy and no bubbles
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d.in_ready", i), {28'd0, in_ready}, 32'(4'b0001 << (i % 4)));
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 4'(4'hA + (i % 4)));
        end

        // idle drain: valid drops, ptr stays at 1
        in_valid = 4'b0000;
        #1;
        chk("drain.in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        chk("drain.valid", {31'd0, out_valid}, 32'h0);
        in_valid = 4'b1111;
        #1;
        chk("drain.resume.in_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        chk_out("drain.resume", 1'b1, 2'd1, 4'hB);

        // backpressure for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", i), {28'd0, in_ready}, 32'h0);
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, 2'd1, 4'hB);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {28'd0, in_ready}, 32'b0100);
        tick();
        chk_out("bp.release", 1'b1, 2'd2, 4'hC);

        // pointer wrap: grant 3, then 0, then 3
        in_valid = 4'b1000;
        #1;
        chk("wrap.a.in_ready", {28'd0, in_ready}, 32'b1000);
        tick();
        chk_out("wrap.a", 1'b1, 2'd3, 4'hD);
        in_valid = 4'b1001;
        #1;
        chk("wrap.b.in_ready", {28'd0, in_ready}, 32'b0001);
        tick();
        chk_out("wrap.b", 1'b1, 2'd0, 4'hA);
        #1;
        chk("wrap.c.in_ready", {28'd0, in_ready}, 32'b1000);
        tick();
        chk_out("wrap.c", 1'b1, 2'd3, 4'hD);

        // sparse traffic with toggling out_ready; ptr is 0 here
        sp_ordy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        sp_ready = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        sp_sel   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        in_valid = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            out_ready = sp_ordy[i];
            #1;
            chk($sformatf("sp%0d.in_ready", i), {28'd0, in_ready}, {28'd0, sp_ready[i]});
            tick();
            chk_out($sformatf("sp%0d", i), 1'b1, sp_sel[i], (sp_sel[i] == 2'd0) ? 4'hA : 4'hB);
        end

        // reset mid-stream with a held word
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_out("rst.mid", 1'b0, 2'd0, 4'h0);
        chk("rst.mid.in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        rst       = 1'b0;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        chk("rst.after.in_ready", {28'd0, in_ready}, 32'b0100);
        tick();
        chk_out("rst.after", 1'b1, 2'd2, 4'hC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
